pipeline_ctrl_unit: RTL and testbench

Central stall/flush/freeze sequencer for the 5-stage pipelined core. It merges the ID-stage load-use stall request, the EX-stage taken-branch flush, and the MEM-stage data-memory request/acknowledge handshake into per-stage register enables and flushes. It also keeps a wait-state timeout, a sticky error flag and a saturating stall-cycle performance counter. It sits beside the hazard detection unit and drives the PC and all four pipeline registers.

---
 rtl/pipeline_ctrl_if.sv | 32 +++
 rtl/pipeline_ctrl_unit.sv | 82 ++++++++
 tb/tb_pipeline_ctrl_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/branch/dmem handshake inputs and stage enable/flush outputs of the pipeline controller
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stall_hazard;
    logic             branch_taken;
    logic             mem_access;
    logic             dmem_ack;
    logic             dmem_req;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             error;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  stall_hazard, branch_taken, mem_access, dmem_ack,
        output dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_flush, error, state, stall_cycles
    );

    modport slave (
        output stall_hazard, branch_taken, mem_access, dmem_ack,
        input  dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_flush, error, state, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: stall/flush/freeze sequencer with dmem wait timeout and saturating stall counter
module pipeline_ctrl_unit #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input logic             clk,
    input logic             arst_n,
    pipeline_ctrl_if.master bus
);
    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_WAIT = 2'b01,
        S_ERR  = 2'b10
    } state_t;

    state_t           st, st_nxt;
    logic [WW-1:0]    wait_cnt;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;
    logic             live, freeze, br, ld, timeout_hit;
    logic             dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic             if_id_flush, id_ex_flush, mem_wb_flush;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) st <= S_RUN;
        else         st <= st_nxt;
    end

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WW'(TIMEOUT - 1));

    always_comb begin
        st_nxt = st == S_RUN  ? ((bus.mem_access && !bus.dmem_ack) ? S_WAIT : S_RUN) :
                 st == S_WAIT ? (bus.dmem_ack ? S_RUN : timeout_hit ? S_ERR : S_WAIT) :
                 S_ERR;
    end

    always_comb begin
        live         = arst_n && (st == S_RUN || st == S_WAIT);
        freeze       = live && !bus.dmem_ack && (st == S_WAIT || bus.mem_access);
        br           = live && !freeze && bus.branch_taken;
        ld           = live && !freeze && !bus.branch_taken && bus.stall_hazard;
        dmem_req     = live && (st == S_WAIT || bus.mem_access);
        pc_write     = live && !freeze && !ld;
        if_id_write  = live && !freeze && !ld;
        id_ex_write  = live && !freeze;
        ex_mem_write = live && !freeze;
        if_id_flush  = br;
        id_ex_flush  = br || ld;
        mem_wb_flush = freeze;
    end

    // wait counter only runs across consecutive un-acked MEM_WAIT cycles
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                              wait_cnt <= '0;
        else if (st == S_WAIT && !bus.dmem_ack)   wait_cnt <= wait_cnt + 1'b1;
        else                                      wait_cnt <= '0;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)              err <= 1'b0;
        else if (st_nxt == S_ERR) err <= 1'b1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                          stall_cnt <= '0;
        else if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.dmem_req     = dmem_req;
    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.id_ex_write  = id_ex_write;
    assign bus.ex_mem_write = ex_mem_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.error        = err;
    assign bus.state        = st;
    assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// tb_pipeline_ctrl_unit: directed checks of stall/flush/freeze, wait states, timeout and counter saturation
module tb_pipeline_ctrl_unit;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(4)) bus();

    pipeline_ctrl_unit #(.CNT_W(4), .TIMEOUT(4)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sh, input logic bt, input logic ma, input logic ack);
        bus.stall_hazard = sh;
        bus.branch_taken = bt;
        bus.mem_access   = ma;
        bus.dmem_ack     = ack;
    endtask

    initial begin
        drive(1, 0, 1, 0);
        #2;
        chk("rst_state", bus.state, 0);
        chk("rst_dmem_req", bus.dmem_req, 0);
        chk("rst_pc_write", bus.pc_write, 0);
        chk("rst_id_ex_flush", bus.id_ex_flush, 0);
        chk("rst_stall_cycles", bus.stall_cycles, 0);
        chk("rst_error", bus.error, 0);
        next();
        drive(0, 0, 0, 0);
        arst_n = 1'b1;
        @(negedge clk);
        chk("idle_pc_write", bus.pc_write, 1);
        chk("idle_ex_mem_write", bus.ex_mem_write, 1);
        chk("idle_flushes", {bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush}, 0);
        chk("idle_dmem_req", bus.dmem_req, 0);
        next();
        drive(1, 0, 0, 0);
        @(negedge clk);
        chk("lu_pc_write", bus.pc_write, 0);
        chk("lu_if_id_write", bus.if_id_write, 0);
        chk("lu_id_ex_flush", bus.id_ex_flush, 1);
        chk("lu_id_ex_write", bus.id_ex_write, 1);
        chk("lu_cnt_before", bus.stall_cycles, 0);
        next();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("lu_release_pc_write", bus.pc_write, 1);
        chk("lu_release_flush", bus.id_ex_flush, 0);
        chk("lu_cnt_after", bus.stall_cycles, 1);
        next();
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("brst_if_id_flush", bus.if_id_flush, 1);
        chk("brst_id_ex_flush", bus.id_ex_flush, 1);
        chk("brst_pc_write", bus.pc_write, 1);
        next();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("brst_cnt", bus.stall_cycles, 1);
        next();
        drive(0, 0, 1, 0);
        @(negedge clk);
        chk("ws_c0_req", bus.dmem_req, 1);
        chk("ws_c0_pc_write", bus.pc_write, 0);
        chk("ws_c0_mem_wb_flush", bus.mem_wb_flush, 1);
        chk("ws_c0_ex_mem_write", bus.ex_mem_write, 0);
        chk("ws_c0_state", bus.state, 0);
        for (int i = 1; i < 3; i++) begin
            next();
            @(negedge clk);
            chk($sformatf("ws_c%0d_state", i), bus.state, 1);
            chk($sformatf("ws_c%0d_req", i), bus.dmem_req, 1);
            chk($sformatf("ws_c%0d_pc_write", i), bus.pc_write, 0);
            chk($sformatf("ws_c%0d_mem_wb_flush", i), bus.mem_wb_flush, 1);
        end
        next();
        drive(0, 0, 1, 1);
        @(negedge clk);
        chk("ws_c3_state", bus.state, 1);
        chk("ws_c3_req", bus.dmem_req, 1);
        chk("ws_c3_pc_write", bus.pc_write, 1);
        chk("ws_c3_mem_wb_flush", bus.mem_wb_flush, 0);
        next();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("ws_c4_state", bus.state, 0);
        chk("ws_c4_req", bus.dmem_req, 0);
        chk("ws_cnt", bus.stall_cycles, 4);
        next();
        drive(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bw_c%0d_if_id_flush", i), bus.if_id_flush, 0);
            chk($sformatf("bw_c%0d_id_ex_flush", i), bus.id_ex_flush, 0);
            next();
        end
        drive(0, 1, 1, 1);
        @(negedge clk);
        chk("bw_c3_if_id_flush", bus.if_id_flush, 1);
        chk("bw_c3_id_ex_flush", bus.id_ex_flush, 1);
        chk("bw_c3_pc_write", bus.pc_write, 1);
        next();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("bw_cnt", bus.stall_cycles, 7);
        next();
        drive(1, 0, 1, 1);
        @(negedge clk);
        chk("zw_req", bus.dmem_req, 1);
        chk("zw_pc_write", bus.pc_write, 0);
        chk("zw_id_ex_flush", bus.id_ex_flush, 1);
        chk("zw_mem_wb_flush", bus.mem_wb_flush, 0);
        next();
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("zw_state", bus.state, 0);
        chk("zw_cnt", bus.stall_cycles, 8);
        next();
        drive(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) next();
        @(negedge clk);
        chk("to_c4_state", bus.state, 1);
        chk("to_c4_error", bus.error, 0);
        chk("to_c4_req", bus.dmem_req, 1);
        next();
        @(negedge clk);
        chk("to_c5_state", bus.state, 2);
        chk("to_c5_error", bus.error, 1);
        chk("to_c5_req", bus.dmem_req, 0);
        chk("to_c5_pc_write", bus.pc_write, 0);
        chk("to_c5_mem_wb_flush", bus.mem_wb_flush, 0);
        chk("to_c5_cnt", bus.stall_cycles, 13);
        next();
        drive(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) next();
        @(negedge clk);
        chk("err_sticky_state", bus.state, 2);
        chk("err_sticky_error", bus.error, 1);
        chk("sat_cnt", bus.stall_cycles, 15);
        next();
        next();
        @(negedge clk);
        chk("sat_hold", bus.stall_cycles, 15);
        #1;
        arst_n = 1'b0;
        #1;
        chk("err_rst_state", bus.state, 0);
        chk("err_rst_error", bus.error, 0);
        chk("err_rst_cnt", bus.stall_cycles, 0);
        drive(0, 0, 0, 0);
        next();
        arst_n = 1'b1;
        drive(0, 0, 1, 0);
        next();
        @(negedge clk);
        chk("mw_state", bus.state, 1);
        chk("mw_cnt", bus.stall_cycles, 1);
        #1;
        arst_n = 1'b0;
        #1;
        chk("mw_rst_state", bus.state, 0);
        chk("mw_rst_req", bus.dmem_req, 0);
        chk("mw_rst_cnt", bus.stall_cycles, 0);
        chk("mw_rst_error", bus.error, 0);
        drive(0, 0, 0, 0);
        next();
        arst_n = 1'b1;
        @(negedge clk);
        chk("rel_pc_write", bus.pc_write, 1);
        chk("rel_flushes", {bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush}, 0);
        chk("rel_state", bus.state, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
